calendar_rtc: RTL

CALENDAR_RTC -- requirements
Module: calendar_rtc

---
 rtl/calendar_rtc_if.sv | 33 +++
 rtl/calendar_rtc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/calendar_rtc_if.sv
// Control inputs and time/date outputs of the calendar RTC, grouped as one bundle.
interface calendar_rtc_if #(
  parameter int unsigned YEAR_W = 12
);
  logic [2:0]        set_sel;
  logic              inc;
  logic              dec;
  logic              mode_12h;
  logic              alarm_en;
  logic [4:0]        alarm_hour;
  logic [5:0]        alarm_min;
  logic [5:0]        sec;
  logic [5:0]        min;
  logic [4:0]        hour;
  logic [4:0]        hour_disp;
  logic              pm;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              is_leap_year;
  logic              tick_1hz;
  logic              alarm_hit;

  modport master (
    output set_sel, inc, dec, mode_12h, alarm_en, alarm_hour, alarm_min,
    input  sec, min, hour, hour_disp, pm, day, month, year, is_leap_year, tick_1hz, alarm_hit
  );

  modport slave (
    input  set_sel, inc, dec, mode_12h, alarm_en, alarm_hour, alarm_min,
    output sec, min, hour, hour_disp, pm, day, month, year, is_leap_year, tick_1hz, alarm_hit
  );
endinterface

// File: rtl/calendar_rtc.sv
// Calendar real-time clock: 1 Hz prescaler, sec..year cascade, field editing, daily alarm.
module calendar_rtc #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BASE_YEAR = 2025,
  parameter int unsigned MAX_YEAR  = 3025,
  parameter int unsigned YEAR_W    = 12
) (
  input logic           clk,
  input logic           rst,
  calendar_rtc_if.slave bus
);
  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0]  PRE_TC = PRE_W'(CLK_HZ - 1);
  localparam logic [YEAR_W-1:0] BASE_Y = YEAR_W'(BASE_YEAR);
  localparam logic [YEAR_W-1:0] MAX_Y  = YEAR_W'(MAX_YEAR);

  function automatic logic leap_of(input logic [YEAR_W-1:0] y);
    int unsigned v;
    v = 32'(y);
    return (((v % 32'd4) == 32'd0) && ((v % 32'd100) != 32'd0)) || ((v % 32'd400) == 32'd0);
  endfunction

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  logic [PRE_W-1:0]  presc, presc_n;
  logic [5:0]        sec_q, sec_n, min_q, min_n;
  logic [4:0]        hour_q, hour_n, day_q, day_n;
  logic [3:0]        month_q, month_n;
  logic [YEAR_W-1:0] year_q, year_n;
  logic              tick_q, tick_n, alarm_q, alarm_n;
  logic              inc_q, dec_q;
  logic              run, rise_inc, rise_dec, up, dn, edit, leap_cur;
  logic [4:0]        dim, new_dim, h12;

  assign run      = (bus.set_sel == 3'd0) || (bus.set_sel == 3'd7);
  assign rise_inc = bus.inc & ~inc_q;
  assign rise_dec = bus.dec & ~dec_q;
  assign up       = rise_inc & ~rise_dec;
  assign dn       = rise_dec & ~rise_inc;
  assign edit     = (up | dn) & ~run;
  assign leap_cur = leap_of(year_q);

  // Next-state: one-shot cascade on a run-mode tick, otherwise a single-field wrapping edit.
  always_comb begin
    sec_n   = sec_q;
    min_n   = min_q;
    hour_n  = hour_q;
    day_n   = day_q;
    month_n = month_q;
    year_n  = year_q;
    alarm_n = 1'b0;
    new_dim = 5'd31;
    presc_n = (presc == PRE_TC) ? '0 : presc + PRE_W'(1);
    dim     = days_in(month_q, leap_cur);
    if (run && tick_q) begin
      if (sec_q == 6'd59) begin
        sec_n = '0;
        if (min_q == 6'd59) begin
          min_n = '0;
          if (hour_q == 5'd23) begin
            hour_n = '0;
            if (day_q >= dim) begin
              day_n = 5'd1;
              if (month_q >= 4'd12) begin
                month_n = 4'd1;
                year_n  = (year_q >= MAX_Y) ? BASE_Y : year_q + YEAR_W'(1);
              end else begin
                month_n = month_q + 4'd1;
              end
            end else begin
              day_n = day_q + 5'd1;
            end
          end else begin
            hour_n = hour_q + 5'd1;
          end
        end else begin
          min_n = min_q + 6'd1;
        end
      end else begin
        sec_n = sec_q + 6'd1;
      end
      alarm_n = bus.alarm_en && (sec_n == 6'd0) && (min_n == bus.alarm_min) &&
                (hour_n == bus.alarm_hour);
    end else if (edit) begin
      case (bus.set_sel)
        3'd1: begin
          sec_n   = up ? ((sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1)
                       : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
          presc_n = '0;
        end
        3'd2: min_n = up ? ((min_q >= 6'd59) ? 6'd0 : min_q + 6'd1)
                         : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
        3'd3: hour_n = up ? ((hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1)
                          : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
        3'd4: day_n = up ? ((day_q >= dim) ? 5'd1 : day_q + 5'd1)
                         : ((day_q <= 5'd1) ? dim : day_q - 5'd1);
        3'd5: begin
          month_n = up ? ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1)
                       : ((month_q <= 4'd1) ? 4'd12 : month_q - 4'd1);
          new_dim = days_in(month_n, leap_cur);
          if (day_q > new_dim) day_n = new_dim;
        end
        3'd6: begin
          year_n  = up ? ((year_q >= MAX_Y) ? BASE_Y : year_q + YEAR_W'(1))
                       : ((year_q <= BASE_Y) ? MAX_Y : year_q - YEAR_W'(1));
          new_dim = days_in(month_q, leap_of(year_n));
          if (day_q > new_dim) day_n = new_dim;
        end
        default: ;
      endcase
    end
    tick_n = (presc_n == PRE_TC);
  end

  // State register with synchronous reset taking priority over ticks and edits.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= BASE_Y;
    end else begin
      presc   <= presc_n;
      tick_q  <= tick_n;
      alarm_q <= alarm_n;
      inc_q   <= bus.inc;
      dec_q   <= bus.dec;
      sec_q   <= sec_n;
      min_q   <= min_n;
      hour_q  <= hour_n;
      day_q   <= day_n;
      month_q <= month_n;
      year_q  <= year_n;
    end
  end

  assign h12              = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q;
  assign bus.hour_disp    = !bus.mode_12h ? hour_q : ((h12 == 5'd0) ? 5'd12 : h12);
  assign bus.pm           = (hour_q >= 5'd12);
  assign bus.is_leap_year = leap_cur;
  assign bus.sec          = sec_q;
  assign bus.min          = min_q;
  assign bus.hour         = hour_q;
  assign bus.day          = day_q;
  assign bus.month        = month_q;
  assign bus.year         = year_q;
  assign bus.tick_1hz     = tick_q;
  assign bus.alarm_hit    = alarm_q;
endmodule
